// File: rtl/gray_ctr.sv
// rtl/gray_ctr.sv - free-running registered Gray-code counter
// Optional checkers compiled only when GRAY_CTR_ASSERT_EN is defined.
`timescale 1ns/1ps
module gray_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("gray_ctr: WIDTH must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;

  assign w_bin_next  = r_bin + WIDTH'(1);
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // q is loaded with the Gray code of the new binary value on the same edge,
  // so it is always a plain flop output with no logic after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bin <= '0;
      r_q   <= '0;
    end else begin
      r_bin <= w_bin_next;
      r_q   <= w_gray_next;
    end
  end

  assign q = r_q;

`ifdef GRAY_CTR_ASSERT_EN
  logic [WIDTH-1:0] r_prev_q;
  logic             r_prev_valid;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_valid <= 1'b0;
      r_prev_q     <= '0;
    end else begin
      r_prev_valid <= 1'b1;
      r_prev_q     <= r_q;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if ($isunknown(r_q))
        $error("%t gray_ctr: q unknown (old %h new %h)", $time, r_prev_q, r_q);
      if (r_q != (r_bin ^ (r_bin >> 1)))
        $error("%t gray_ctr: q %h not gray of bin %h", $time, r_q, r_bin);
      if (r_prev_valid && ($countones(r_q ^ r_prev_q) != 1))
        $error("%t gray_ctr: q changed %h -> %h", $time, r_prev_q, r_q);
    end
  end
`endif

endmodule

// File: tb/tb_gray_ctr.sv
// tb/tb_gray_ctr.sv - randomized self-checking bench for gray_ctr (WIDTH 1, 4, 8)
`timescale 1ns/100ps
module tb_gray_ctr;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [0:0] q1;
  logic [3:0] q4;
  logic [7:0] q8;

  int n_checks = 0;
  int n_err    = 0;
  int k        = 0;
  int prev_k   = -10;
  logic [0:0] p1;
  logic [3:0] p4;
  logic [7:0] p8;
  bit started  = 1'b0;
  logic [3:0] seq4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_ctr #(.WIDTH(1)) u_w1 (.clk(clk), .reset(reset), .q(q1));
  gray_ctr #(.WIDTH(4)) u_w4 (.clk(clk), .reset(reset), .q(q4));
  gray_ctr #(.WIDTH(8)) u_w8 (.clk(clk), .reset(reset), .q(q8));

  always #1 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gray(input int kk, input int w);
    int m;
    m = kk % (1 << w);
    return 32'(m ^ (m >> 1));
  endfunction

  // Reference: number of counting edges since the last reset assertion.
  always @(posedge clk or negedge reset) begin
    if (!reset) k = 0;
    else        k = k + 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_q1", 32'(q1), gray(k, 1));
      chk("model_q4", 32'(q4), gray(k, 4));
      chk("model_q8", 32'(q8), gray(k, 8));
      if (k == prev_k + 1) begin
        chk("hamming_q1", 32'($countones(q1 ^ p1)), 32'd1);
        chk("hamming_q4", 32'($countones(q4 ^ p4)), 32'd1);
        chk("hamming_q8", 32'($countones(q8 ^ p8)), 32'd1);
      end
      prev_k = k;
      p1 = q1;
      p4 = q4;
      p8 = q8;
    end
  end

  initial begin
    #0.2 reset = 1'b0;
    #0.2;
    started = 1'b1;
    chk("reset_async_q4", 32'(q4), 32'h0);
    chk("reset_async_q8", 32'(q8), 32'h0);
    #2.1 reset = 1'b1;                       // t=2.5, between edges
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #0.5;
      chk("seq4", 32'(q4), 32'(seq4[i % 16]));
    end
    @(posedge clk); #0.5;
    chk("wrap4_next", 32'(q4), 32'h1);
    chk("w1_alt", 32'(q1), 32'h1);
    repeat (238) @(posedge clk);
    #0.5;
    chk("w8_top", 32'(q8), 32'h80);
    @(posedge clk); #0.5;
    chk("w8_wrap", 32'(q8), 32'h00);
    chk("w1_even", 32'(q1), 32'h0);
    repeat (5) @(posedge clk);
    #0.5;
    chk("mid_q4_7", 32'(q4), 32'h7);
    reset = 1'b0;
    #0.2;
    chk("mid_async_clear", 32'(q4), 32'h0);
    repeat (2) @(posedge clk);
    #0.5;
    chk("mid_hold_low", 32'(q4), 32'h0);
    reset = 1'b1;
    @(posedge clk); #0.5;
    chk("mid_first_edge", 32'(q4), 32'h1);
    for (int i = 0; i < 10; i++) begin
      reset = 1'($urandom_range(0, 1));
      #2;
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 40)) @(posedge clk);
      #0.5 reset = 1'b0;
      #(2 * $urandom_range(0, 2) + 0.2);
      chk("rand_low_q8", 32'(q8), 32'h0);
      #1.8 reset = 1'b1;
    end
    repeat (300) @(posedge clk);
    #0.5;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
